// File: rtl/stack_unit.sv
// LIFO operand stack for the multicycle stack-machine controller.
// Supports push/pop/peek/swap commands, a registered data_out, and sticky error flags.
module stack_unit #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              stack_push,
    input  logic              stack_pop,
    input  logic              tos,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              out_valid,
    output logic              zero,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE        = (ADDR_W + 1)'(1);

    logic [WIDTH-1:0]  mem [DEPTH];

    logic [ADDR_W:0]   count_q,     count_d;
    logic [WIDTH-1:0]  dataOut_q,   dataOut_d;
    logic              outValid_q,  outValid_d;
    logic              overflow_q,  overflow_d;
    logic              underflow_q, underflow_d;

    logic              writeEn;
    logic [ADDR_W-1:0] writeAddr;
    logic [ADDR_W:0]   topCount;
    logic [ADDR_W-1:0] topIdx;
    logic              isEmpty;
    logic              isFull;

    assign isEmpty  = (count_q == '0);
    assign isFull   = (count_q == FULL_COUNT);
    assign topCount = count_q - ONE;
    assign topIdx   = topCount[ADDR_W-1:0];

    // A swap on an empty stack degenerates into a push of data_in to slot 0.
    always_comb begin
        count_d     = count_q;
        dataOut_d   = dataOut_q;
        outValid_d  = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        writeEn     = 1'b0;
        writeAddr   = count_q[ADDR_W-1:0];

        if (clear) begin
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            unique case ({stack_push, stack_pop})
                2'b10: begin
                    if (!isFull) begin
                        writeEn = 1'b1;
                        count_d = count_q + ONE;
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (!isEmpty) begin
                        dataOut_d  = mem[topIdx];
                        outValid_d = 1'b1;
                        count_d    = topCount;
                    end else begin
                        underflow_d = 1'b1;
                    end
                end
                2'b11: begin
                    writeEn = 1'b1;
                    if (!isEmpty) begin
                        writeAddr  = topIdx;
                        dataOut_d  = mem[topIdx];
                        outValid_d = 1'b1;
                    end else begin
                        count_d     = ONE;
                        underflow_d = 1'b1;
                    end
                end
                default: begin
                    if (tos && !isEmpty) begin
                        dataOut_d  = mem[topIdx];
                        outValid_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            dataOut_q   <= '0;
            outValid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            dataOut_q   <= dataOut_d;
            outValid_q  <= outValid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Entry storage carries no reset; only written slots are ever read back.
    always_ff @(posedge clk) begin
        if (writeEn) begin
            mem[writeAddr] <= data_in;
        end
    end

    assign data_out  = dataOut_q;
    assign out_valid = outValid_q;
    assign zero      = (dataOut_q == '0);
    assign count     = count_q;
    assign empty     = isEmpty;
    assign full      = isFull;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_stack_unit.sv
// Testbench for stack_unit: directed scenarios plus randomized commands against a queue model.
module tb_stack_unit;

    logic       clk;
    logic       rst;
    logic       clear;
    logic       stack_push;
    logic       stack_pop;
    logic       tos;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       out_valid;
    logic       zero;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       underflow;

    int testsRun    = 0;
    int testsFailed = 0;

    stack_unit #(.WIDTH(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .stack_push (stack_push),
        .stack_pop  (stack_pop),
        .tos        (tos),
        .data_in    (data_in),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .zero       (zero),
        .count      (count),
        .empty      (empty),
        .full       (full),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1ns after an edge, are sampled at the next edge, and outputs are read 1ns later.
    task automatic step(input logic p, input logic o, input logic t, input logic c, input logic [7:0] d);
        stack_push = p;
        stack_pop  = o;
        tos        = t;
        clear      = c;
        data_in    = d;
        @(posedge clk);
        #1;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        tos        = 1'b0;
        clear      = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        testsRun++;
        if ({count, data_out, zero, out_valid, overflow, underflow, empty, full} !==
            {5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: got count=%0d dout=%h z=%b v=%b ov=%b un=%b e=%b f=%b, want 0 00 1 0 0 0 1 0",
                     count, data_out, zero, out_valid, overflow, underflow, empty, full);
        end
        rst = 1'b0;
    endtask

    task automatic test_push_pop();
        step(1, 0, 0, 0, 8'h05);
        step(1, 0, 0, 0, 8'h03);
        step(1, 0, 0, 0, 8'h07);
        testsRun++;
        if (count !== 5'd3) begin
            testsFailed++;
            $display("[TB] FAIL push3_count: got %0d want 3", count);
        end
        step(0, 1, 0, 0, 8'h00);
        testsRun++;
        if (data_out !== 8'h07 || out_valid !== 1'b1 || count !== 5'd2) begin
            testsFailed++;
            $display("[TB] FAIL pop_07: got dout=%h v=%b count=%0d want 07 1 2", data_out, out_valid, count);
        end
        step(0, 1, 0, 0, 8'h00);
        testsRun++;
        if (data_out !== 8'h03) begin
            testsFailed++;
            $display("[TB] FAIL pop_03: got %h want 03", data_out);
        end
        step(0, 1, 0, 0, 8'h00);
        testsRun++;
        if (data_out !== 8'h05 || empty !== 1'b1 || zero !== 1'b0 || out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL pop_05: got dout=%h e=%b z=%b v=%b want 05 1 0 1", data_out, empty, zero, out_valid);
        end
    endtask

    task automatic test_tos();
        step(1, 0, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        testsRun++;
        if (data_out !== 8'h00 || zero !== 1'b1 || count !== 5'd1 || out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL tos_zero: got dout=%h z=%b count=%0d v=%b want 00 1 1 1", data_out, zero, count, out_valid);
        end
        step(0, 0, 0, 0, 8'h00);
        testsRun++;
        if (out_valid !== 1'b0 || data_out !== 8'h00) begin
            testsFailed++;
            $display("[TB] FAIL idle_hold: got v=%b dout=%h want 0 00", out_valid, data_out);
        end
        step(0, 1, 0, 0, 8'h00);
    endtask

    task automatic test_full_overflow();
        for (int i = 1; i <= 16; i++) step(1, 0, 0, 0, 8'(i));
        testsRun++;
        if (full !== 1'b1 || count !== 5'd16) begin
            testsFailed++;
            $display("[TB] FAIL fill: got full=%b count=%0d want 1 16", full, count);
        end
        step(1, 0, 0, 0, 8'hAA);
        testsRun++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            testsFailed++;
            $display("[TB] FAIL overflow: got ov=%b count=%0d want 1 16", overflow, count);
        end
        for (int i = 16; i >= 1; i--) begin
            step(0, 1, 0, 0, 8'h00);
            testsRun++;
            if (data_out !== 8'(i) || out_valid !== 1'b1) begin
                testsFailed++;
                $display("[TB] FAIL drain_%0d: got dout=%h v=%b want %h 1", i, data_out, out_valid, 8'(i));
            end
        end
        step(0, 1, 0, 0, 8'h00);
        testsRun++;
        if (underflow !== 1'b1 || data_out !== 8'h01 || out_valid !== 1'b0 || count !== 5'd0) begin
            testsFailed++;
            $display("[TB] FAIL underflow: got un=%b dout=%h v=%b count=%0d want 1 01 0 0",
                     underflow, data_out, out_valid, count);
        end
        step(0, 0, 0, 1, 8'h00);
    endtask

    task automatic test_swap();
        step(1, 0, 0, 0, 8'h11);
        step(1, 0, 0, 0, 8'h22);
        step(1, 1, 0, 0, 8'h33);
        testsRun++;
        if (data_out !== 8'h22 || count !== 5'd2 || out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL swap: got dout=%h count=%0d v=%b want 22 2 1", data_out, count, out_valid);
        end
        step(0, 1, 0, 0, 8'h00);
        testsRun++;
        if (data_out !== 8'h33) begin
            testsFailed++;
            $display("[TB] FAIL swap_pop1: got %h want 33", data_out);
        end
        step(0, 1, 0, 0, 8'h00);
        testsRun++;
        if (data_out !== 8'h11) begin
            testsFailed++;
            $display("[TB] FAIL swap_pop2: got %h want 11", data_out);
        end
    endtask

    task automatic test_swap_empty();
        step(1, 1, 0, 0, 8'h44);
        testsRun++;
        if (count !== 5'd1 || underflow !== 1'b1 || out_valid !== 1'b0 || data_out !== 8'h11) begin
            testsFailed++;
            $display("[TB] FAIL swap_empty: got count=%0d un=%b v=%b dout=%h want 1 1 0 11",
                     count, underflow, out_valid, data_out);
        end
        step(0, 0, 1, 0, 8'h00);
        testsRun++;
        if (data_out !== 8'h44 || out_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL swap_empty_tos: got dout=%h v=%b want 44 1", data_out, out_valid);
        end
        step(0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 8'h00);
        testsRun++;
        if (out_valid !== 1'b0 || data_out !== 8'h44 || underflow !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL tos_empty: got v=%b dout=%h un=%b want 0 44 1", out_valid, data_out, underflow);
        end
    endtask

    task automatic test_clear_and_reset();
        for (int i = 0; i < 17; i++) step(1, 0, 0, 0, 8'h60 + 8'(i));
        testsRun++;
        if (overflow !== 1'b1 || underflow !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flags_set: got ov=%b un=%b want 1 1", overflow, underflow);
        end
        step(1, 0, 0, 1, 8'h55);
        testsRun++;
        if (count !== 5'd0 || overflow !== 1'b0 || underflow !== 1'b0 || out_valid !== 1'b0 || data_out !== 8'h44) begin
            testsFailed++;
            $display("[TB] FAIL clear: got count=%0d ov=%b un=%b v=%b dout=%h want 0 0 0 0 44",
                     count, overflow, underflow, out_valid, data_out);
        end
        step(1, 0, 0, 0, 8'h81);
        step(1, 0, 0, 0, 8'h82);
        step(1, 0, 0, 0, 8'h83);
        step(0, 0, 1, 0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        testsRun++;
        if (count !== 5'd0 || data_out !== 8'h00 || zero !== 1'b1 || out_valid !== 1'b0 || empty !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL async_reset: got count=%0d dout=%h z=%b v=%b e=%b want 0 00 1 0 1",
                     count, data_out, zero, out_valid, empty);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1, 0, 0, 0, 8'h9C);
        testsRun++;
        if (count !== 5'd1) begin
            testsFailed++;
            $display("[TB] FAIL post_reset_push: got count=%0d want 1", count);
        end
        step(0, 0, 0, 1, 8'h00);
    endtask

    // Reference model: a queue whose last element is the top of stack.
    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] expData;
        logic       expValid;
        logic       expOv;
        logic       expUn;
        logic       p, o, t, c;
        logic [7:0] d;
        int         sel;
        expData = data_out;
        expOv   = 1'b0;
        expUn   = 1'b0;
        for (int n = 0; n < 400; n++) begin
            sel = int'($urandom_range(0, 99));
            p = 1'b0; o = 1'b0; c = 1'b0;
            t = 1'($urandom_range(0, 1));
            d = 8'($urandom_range(0, 255));
            if (sel < 40)      p = 1'b1;
            else if (sel < 68) o = 1'b1;
            else if (sel < 80) begin p = 1'b1; o = 1'b1; end
            else if (sel < 98) ;
            else               c = 1'b1;
            step(p, o, t, c, d);

            expValid = 1'b0;
            if (c) begin
                q.delete();
                expOv = 1'b0;
                expUn = 1'b0;
            end else if (p && o) begin
                if (q.size() > 0) begin
                    expData = q[q.size() - 1];
                    q[q.size() - 1] = d;
                    expValid = 1'b1;
                end else begin
                    q.push_back(d);
                    expUn = 1'b1;
                end
            end else if (p) begin
                if (q.size() < 16) q.push_back(d);
                else expOv = 1'b1;
            end else if (o) begin
                if (q.size() > 0) begin
                    expData = q.pop_back();
                    expValid = 1'b1;
                end else begin
                    expUn = 1'b1;
                end
            end else if (t && q.size() > 0) begin
                expData = q[q.size() - 1];
                expValid = 1'b1;
            end

            testsRun++;
            if (count !== 5'(q.size()) || data_out !== expData || out_valid !== expValid ||
                overflow !== expOv || underflow !== expUn || empty !== (q.size() == 0) ||
                full !== (q.size() == 16) || zero !== (expData == 8'h00)) begin
                testsFailed++;
                $display("[TB] FAIL random_%0d: got count=%0d dout=%h v=%b ov=%b un=%b e=%b f=%b z=%b, want count=%0d dout=%h v=%b ov=%b un=%b",
                         n, count, data_out, out_valid, overflow, underflow, empty, full, zero,
                         q.size(), expData, expValid, expOv, expUn);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        clear      = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        tos        = 1'b0;
        data_in    = 8'h00;
        test_reset();
        test_push_pop();
        test_tos();
        test_full_overflow();
        test_swap();
        test_swap_empty();
        test_clear_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Hardware operand stack that responds to the push/pop/top-of-stack commands issued by the multicycle stack-machine controller.
- Holds WIDTH-bit entries in a LIFO array and returns popped or peeked values through a registered data_out.
- data_out feeds the ALU operand paths and memory write data.
- Provides the zero flag used by jump-if-zero, plus full/empty status and sticky error flags.

Parameters:
- WIDTH, 8, entry and data bus width in bits.
- ADDR_W, 4, log2 of the stack depth.
- DEPTH, 2**ADDR_W (16), number of entries; derived, not overridden independently.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high; clears all state immediately.
- clear  in  1  synchronous empty: count to 0 and error flags cleared; highest priority after rst.
- stack_push  in  1  push data_in this cycle.
- stack_pop  in  1  remove the top entry and load it into data_out.
- tos  in  1  copy the top entry into data_out without removing it.
- data_in  in  WIDTH  value to push.
- data_out  out  WIDTH  registered result of the last successful pop, tos or swap.
- out_valid  out  1  one-cycle pulse; data_out was updated at this edge.
- zero  out  1  high when data_out == 0; combinational from the data_out register.
- count  out  ADDR_W+1  number of valid entries, 0..DEPTH.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- overflow  out  1  sticky; a push was attempted while full.
- underflow  out  1  sticky; a pop or swap was attempted while empty.

Behaviour:
- Reset values: count 0, data_out 0, zero 1, out_valid 0, overflow 0, underflow 0, empty 1, full 0.
- Array contents are not reset. A bench may only check entries that have been written.
- Top entry is mem[count-1]. Push writes mem[count].
- Latency: data_out and out_valid update at the same edge that samples the command. The value is readable in the following cycle.
- out_valid is 0 in every cycle with no successful pop, tos or swap.
- Per-edge priority: rst (async) > clear > command decode.
- clear: count <= 0, overflow <= 0, underflow <= 0. data_out is held. out_valid <= 0. Any command in the same cycle is ignored.
- Command decode on {stack_push, stack_pop}:
  - 00, tos=1, non-empty: data_out <= top, out_valid 1, count unchanged.
  - 00, tos=1, empty: no change, out_valid 0, no flag set.
  - 00, tos=0: idle.
  - 10, not full: mem[count] <= data_in, count+1.
  - 10, full: no write, count held, overflow <= 1.
  - 01, non-empty: data_out <= top, count-1, out_valid 1.
  - 01, empty: data_out held, count held, out_valid 0, underflow <= 1.
  - 11 (swap), non-empty: data_out <= old top, mem[count-1] <= data_in, count unchanged, out_valid 1. Full is irrelevant.
  - 11 (swap), empty: executes as a plain push (count becomes 1), underflow <= 1, out_valid 0.
- tos is ignored whenever stack_push or stack_pop is high.
- count never wraps. It saturates logically at 0 and DEPTH via the rules above.
- Sticky flags are cleared only by rst or clear.
- rst asserted mid-sequence: all outputs take their reset values asynchronously, without waiting for a clock edge.
- After rst deasserts, the first edge may accept a command.

Test Plan:
- Reset, then push 8'h05, 8'h03, 8'h07 on consecutive edges -> count 3. pop -> data_out 07, out_valid 1. pop -> 03. pop -> 05, empty 1, zero 0.
- Push 8'h00, then tos -> data_out 00, zero 1, count stays 1. Next cycle idle -> out_valid 0, data_out held 00.
- Push 16 values 1..16 -> full 1. Push 8'hAA -> overflow 1, count 16. Pop 16 times -> values 16..1 in order. Pop again -> underflow 1, data_out held 01, out_valid 0.
- Stack {0x11, 0x22 top}, assert push+pop with data_in 0x33 -> data_out 22, count 2. Pop -> 33, then pop -> 11.
- Empty stack, assert push+pop with data_in 0x44 -> count 1, underflow 1, out_valid 0. tos -> data_out 44.
- After error flags are set, assert clear with a push in the same cycle -> count 0, flags 0, push ignored. Push 3 entries, assert rst mid-cycle between edges -> count 0, data_out 0, zero 1 immediately, before the next edge.
